// File: rtl/dbus_wait_pkg.sv
// Shared types and helpers for the wait-state data-bus responder.
package dbus_wait_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} resp_state_t;

  localparam int MAX_WAIT = 15;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dbus_wait_responder_if.sv
// naive_mips data-bus signal bundle; master is the CPU side, slave the responder.
interface dbus_wait_responder_if;
  logic [31:0] dbus_address;
  logic [3:0]  dbus_byteenable;
  logic        dbus_read;
  logic        dbus_write;
  logic [31:0] dbus_wrdata;
  logic [31:0] dbus_rddata;
  logic        dbus_stall;
  logic        proto_err;

  modport master (
    output dbus_address, dbus_byteenable, dbus_read, dbus_write, dbus_wrdata,
    input  dbus_rddata, dbus_stall, proto_err
  );

  modport slave (
    input  dbus_address, dbus_byteenable, dbus_read, dbus_write, dbus_wrdata,
    output dbus_rddata, dbus_stall, proto_err
  );
endinterface

// File: rtl/dbus_wait_wordmem.sv
// Word-addressed RAM with per-byte write enables and an asynchronous read port.
module dbus_wait_wordmem
  import dbus_wait_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= lane_merge(mem[waddr], wdata, be);
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dbus_wait_responder.sv
// Data-bus slave that serves a word RAM after WAIT_CYCLES stall cycles per access.
// Define DBUS_WAIT_RESPONDER_PROTO_CHECK_EN to flag requests that change while stalled.
module dbus_wait_responder
  import dbus_wait_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  dbus_wait_responder_if.slave bus
);

  // Out-of-range settings saturate rather than silently growing the counter.
  localparam int WAIT_EFF = (WAIT_CYCLES > MAX_WAIT) ? MAX_WAIT : WAIT_CYCLES;
  localparam int CNT_W    = (WAIT_EFF > 0) ? $clog2(WAIT_EFF + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_EFF);

  resp_state_t           state;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic                  req;
  logic                  rw_clash;
  logic                  complete;
  logic                  stall;
  logic                  we;
  logic                  viol;
  logic                  proto_err_q;
  logic [ADDR_WIDTH-1:0] word;
  logic [31:0]           mem_rdata;
  logic                  unused_addr_bits;

  assign req              = bus.dbus_read | bus.dbus_write;
  assign rw_clash         = bus.dbus_read & bus.dbus_write;
  assign word             = bus.dbus_address[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{bus.dbus_address[31:ADDR_WIDTH+2], bus.dbus_address[1:0]};
  assign cnt_next         = cnt + CNT_ONE;

  always_comb begin
    complete = 1'b0;
    stall    = 1'b0;
    if (rst_n && req) begin
      if (WAIT_EFF == 0) begin
        complete = 1'b1;
      end else begin
        case (state)
          IDLE, WAIT: stall    = 1'b1;
          DONE:       complete = 1'b1;
          default:    stall    = 1'b0;
        endcase
      end
    end
  end

  // cnt holds the number of stall cycles already spent on the current request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req && (WAIT_EFF != 0)) begin
            cnt   <= CNT_ONE;
            state <= (CNT_ONE == CNT_LAST) ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (!req) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt_next;
            if (cnt_next == CNT_LAST) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proto_err_q <= 1'b0;
    end else if (rw_clash || viol) begin
      proto_err_q <= 1'b1;
    end
  end

`ifdef DBUS_WAIT_RESPONDER_PROTO_CHECK_EN
  logic [31:0] cap_address;
  logic [31:0] cap_wrdata;
  logic [3:0]  cap_be;
  logic        cap_read;
  logic        cap_write;
  logic        bad_address;
  logic        bad_be;
  logic        bad_wrdata;
  logic        bad_read;
  logic        bad_write;
  logic        checking;

  // Snapshot the request in the cycle its stall window opens.
  always_ff @(posedge clk) begin
    if (stall && (state == IDLE)) begin
      cap_address <= bus.dbus_address;
      cap_be      <= bus.dbus_byteenable;
      cap_wrdata  <= bus.dbus_wrdata;
      cap_read    <= bus.dbus_read;
      cap_write   <= bus.dbus_write;
    end
  end

  assign checking    = stall && (state != IDLE);
  assign bad_address = checking && (bus.dbus_address    != cap_address);
  assign bad_be      = checking && (bus.dbus_byteenable != cap_be);
  assign bad_wrdata  = checking && (bus.dbus_wrdata     != cap_wrdata);
  assign bad_read    = checking && (bus.dbus_read       != cap_read);
  assign bad_write   = checking && (bus.dbus_write      != cap_write);
  assign viol        = bad_address | bad_be | bad_wrdata | bad_read | bad_write;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (bad_address) $display("%0t dbus_wait_responder: dbus_address changed while stalled", $time);
      if (bad_be)      $display("%0t dbus_wait_responder: dbus_byteenable changed while stalled", $time);
      if (bad_wrdata)  $display("%0t dbus_wait_responder: dbus_wrdata changed while stalled", $time);
      if (bad_read)    $display("%0t dbus_wait_responder: dbus_read changed while stalled", $time);
      if (bad_write)   $display("%0t dbus_wait_responder: dbus_write changed while stalled", $time);
    end
  end
`endif
`else
  assign viol = 1'b0;
`endif

  assign we              = complete & bus.dbus_write;
  assign bus.dbus_stall  = stall;
  assign bus.dbus_rddata = (complete && bus.dbus_read) ? mem_rdata : 32'h0;
  assign bus.proto_err   = proto_err_q;

  dbus_wait_wordmem #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (we),
    .be   (bus.dbus_byteenable),
    .waddr(word),
    .wdata(bus.dbus_wrdata),
    .raddr(word),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_dbus_wait_responder.sv
// Directed bench for dbus_wait_responder: one instance with 2 wait states, one with none,
// both driven by the same bus and checked every cycle against a latency/RAM model.
module tb_dbus_wait_responder;
  localparam int AW = 12;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr  = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [3:0]  be    = 4'h0;
  logic        rd    = 1'b0;
  logic        wr    = 1'b0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  dbus_wait_responder_if bus0 ();
  dbus_wait_responder_if bus1 ();

  assign bus0.dbus_address    = addr;
  assign bus0.dbus_byteenable = be;
  assign bus0.dbus_read       = rd;
  assign bus0.dbus_write      = wr;
  assign bus0.dbus_wrdata     = wdata;
  assign bus1.dbus_address    = addr;
  assign bus1.dbus_byteenable = be;
  assign bus1.dbus_read       = rd;
  assign bus1.dbus_write      = wr;
  assign bus1.dbus_wrdata     = wdata;

  dbus_wait_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  dbus_wait_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  // Model: a request that has been outstanding for N cycles completes when N reaches the wait count.
  int          age    [2] = '{0, 0};
  logic        perr_m [2] = '{1'b0, 1'b0};
  logic [31:0] mem_m  [2][4096];
  bit          vld    [2][4096];

  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'(a[AW+1:2]);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        age[d]    = 0;
        perr_m[d] = 1'b0;
      end else begin
        if (rd && wr) perr_m[d] = 1'b1;
        if (!(rd || wr)) begin
          age[d] = 0;
        end else if (age[d] < wait_of(d)) begin
          age[d] = age[d] + 1;
        end else begin
          if (wr) begin
            for (int b = 0; b < 4; b++) begin
              if (be[b]) mem_m[d][word_of(addr)][8*b +: 8] = wdata[8*b +: 8];
            end
            if (be == 4'hF) vld[d][word_of(addr)] = 1'b1;
          end
          age[d] = 0;
        end
      end
    end
  end

  logic        exp_stall;
  logic        exp_perr;
  logic        rd_known;
  logic [31:0] exp_rdata;
  logic        act_stall;
  logic        act_perr;
  logic [31:0] act_rdata;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      exp_stall = 1'b0;
      exp_rdata = 32'h0;
      rd_known  = 1'b1;
      exp_perr  = rst_n ? perr_m[d] : 1'b0;
      if (rst_n && (rd || wr)) begin
        if (age[d] < wait_of(d)) begin
          exp_stall = 1'b1;
        end else if (rd) begin
          exp_rdata = mem_m[d][word_of(addr)];
          rd_known  = vld[d][word_of(addr)];
        end
      end
      act_stall = (d == 0) ? bus0.dbus_stall  : bus1.dbus_stall;
      act_rdata = (d == 0) ? bus0.dbus_rddata : bus1.dbus_rddata;
      act_perr  = (d == 0) ? bus0.proto_err   : bus1.proto_err;
      checkOutput($sformatf("model dut%0d stall @%0t", d, $time), 32'(act_stall), 32'(exp_stall));
      if (rd_known) checkOutput($sformatf("model dut%0d rddata @%0t", d, $time), act_rdata, exp_rdata);
      checkOutput($sformatf("model dut%0d proto_err @%0t", d, $time), 32'(act_perr), 32'(exp_perr));
    end
  end

  task automatic applyStimulus(input logic r, input logic w, input logic [31:0] a,
                               input logic [3:0] b, input logic [31:0] d);
    @(posedge clk);
    #1;
    rd = r; wr = w; addr = a; be = b; wdata = d;
  endtask

  // Holds one request on the bus until dut0 completes it; counts dut0 stall cycles.
  task automatic do_access(input logic r, input logic w, input logic [31:0] a, input logic [3:0] b,
                           input logic [31:0] d, input bit already_applied,
                           output logic [31:0] rdata, output int stalls);
    bit done;
    done   = 1'b0;
    stalls = 0;
    rdata  = 32'h0;
    if (!already_applied) applyStimulus(r, w, a, b, d);
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (bus0.dbus_stall === 1'b0) begin
        rdata = bus0.dbus_rddata;
        done  = 1'b1;
      end else begin
        stalls++;
        @(posedge clk);
        #1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL access timeout: stall %b after 40 cycles, want 0", bus0.dbus_stall);
    end
  endtask

  initial begin
    logic [31:0] rdata;
    int          stalls;

    // Request present during reset must not stall or return data.
    rd   = 1'b1;
    addr = 32'h10;
    @(negedge clk);
    checkOutput("reset stall dut0", 32'(bus0.dbus_stall), 32'h0);
    checkOutput("reset stall dut1", 32'(bus1.dbus_stall), 32'h0);
    checkOutput("reset rddata dut1", bus1.dbus_rddata, 32'h0);
    checkOutput("reset proto_err", 32'(bus0.proto_err), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    do_access(1'b0, 1'b1, 32'h8000_0010, 4'hF, 32'hDEAD_BEEF, 1'b0, rdata, stalls);
    checkOutput("write stall cycles", 32'(stalls), 32'd2);
    do_access(1'b1, 1'b0, 32'h8000_0010, 4'hF, 32'h0, 1'b0, rdata, stalls);
    checkOutput("read stall cycles", 32'(stalls), 32'd2);
    checkOutput("read after write", rdata, 32'hDEAD_BEEF);

    do_access(1'b0, 1'b1, 32'h20, 4'hF, 32'h1122_3344, 1'b0, rdata, stalls);
    do_access(1'b0, 1'b1, 32'h20, 4'b0100, 32'h00AA_0000, 1'b0, rdata, stalls);
    do_access(1'b1, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, rdata, stalls);
    checkOutput("lane merge", rdata, 32'h11AA_3344);

    do_access(1'b0, 1'b1, 32'h20, 4'h0, 32'hFFFF_FFFF, 1'b0, rdata, stalls);
    checkOutput("be0 stall cycles", 32'(stalls), 32'd2);

    // Flush inside WAIT: one cycle of request, dropped on the next.
    applyStimulus(1'b0, 1'b1, 32'h20, 4'hF, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 1'b0, 32'h20, 4'h0, 32'h0);
    @(negedge clk);
    checkOutput("flush in wait stall", 32'(bus0.dbus_stall), 32'h0);
    // Flush in the completion cycle.
    applyStimulus(1'b0, 1'b1, 32'h20, 4'hF, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 32'h20, 4'h0, 32'h0);
    @(negedge clk);
    checkOutput("flush in done rddata", bus0.dbus_rddata, 32'h0);
    do_access(1'b1, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, rdata, stalls);
    checkOutput("fresh count after flush", 32'(stalls), 32'd2);
    checkOutput("word kept after flush", rdata, 32'h11AA_3344);

    do_access(1'b0, 1'b1, 32'h30, 4'hF, 32'h5555_5555, 1'b0, rdata, stalls);
    do_access(1'b1, 1'b1, 32'h30, 4'hF, 32'h0, 1'b0, rdata, stalls);
    checkOutput("rw clash pre-write data", rdata, 32'h5555_5555);
    do_access(1'b1, 1'b0, 32'h30, 4'hF, 32'h0, 1'b0, rdata, stalls);
    checkOutput("rw clash wrote word", rdata, 32'h0);
    checkOutput("rw clash proto_err", 32'(bus0.proto_err), 32'h1);

    do_access(1'b1, 1'b0, 32'h4000_4013, 4'h0, 32'h0, 1'b0, rdata, stalls);
    checkOutput("address alias", rdata, 32'hDEAD_BEEF);

    // Zero-wait instance: alternate write/read every cycle.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h100 + 32'(4*i), 4'hF, 32'hA5A5_0000 + 32'(i));
      @(negedge clk);
      checkOutput("zero-wait write stall", 32'(bus1.dbus_stall), 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h100 + 32'(4*i), 4'hF, 32'h0);
      @(negedge clk);
      checkOutput("zero-wait read stall", 32'(bus1.dbus_stall), 32'h0);
      checkOutput("zero-wait read data", bus1.dbus_rddata, 32'hA5A5_0000 + 32'(i));
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

    // Reset during WAIT with a write pending: write must be lost.
    applyStimulus(1'b0, 1'b1, 32'h30, 4'hF, 32'h7777_7777);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("reset mid-wait stall", 32'(bus0.dbus_stall), 32'h0);
    checkOutput("reset mid-wait proto_err", 32'(bus0.proto_err), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rd    = 1'b0;
    wr    = 1'b0;
    do_access(1'b1, 1'b0, 32'h30, 4'hF, 32'h0, 1'b0, rdata, stalls);
    checkOutput("write discarded by reset", rdata, 32'h0);

    // Read held across reset restarts its count after release.
    applyStimulus(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_access(1'b1, 1'b0, 32'h10, 4'hF, 32'h0, 1'b1, rdata, stalls);
    checkOutput("restart stall cycles", 32'(stalls), 32'd2);
    checkOutput("restart read data", rdata, 32'hDEAD_BEEF);

    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
